// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: FSM encoding, the x0 constant,
// the pipeline-control bundle and its canned run/stall/hold values.
package hazard_stall_unit_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bundle order is fixed; the top unpacks it field by field onto its ports.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    function automatic logic reg_match(input logic       use_rs,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_rs && (rs != REG_ZERO) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             inc,
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-on-load stall generation and cache-miss freeze for the
// 5-stage core, with saturating stall, freeze and flush counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             branch,
    input  logic             jalr,
    input  logic             redirect,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_memread,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             hazard_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_t    state;
    logic      cnt;
    logic      freeze;
    logic      dep_ex;
    logic      dep_mem;
    logic      is_ctrl;
    logic      haz_lu;
    logic      haz_bl1;
    logic      haz_bl2;
    logic      haz_any;
    pipe_ctl_t ctl;

    assign freeze  = ICACHE_stall | DCACHE_stall;
    assign is_ctrl = branch | jalr;
    assign dep_ex  = reg_match(use_rs1, IF_ID_rs1, ID_EX_rd)
                   | reg_match(use_rs2, IF_ID_rs2, ID_EX_rd);
    assign dep_mem = reg_match(use_rs1, IF_ID_rs1, EX_MEM_rd)
                   | reg_match(use_rs2, IF_ID_rs2, EX_MEM_rd);

    assign haz_lu  = ID_EX_memread & dep_ex;
    assign haz_bl2 = is_ctrl & haz_lu;
    assign haz_bl1 = is_ctrl & EX_MEM_memread & dep_mem;
    assign haz_any = (state == RUN) & (haz_lu | haz_bl1);

    always_comb begin
        ctl = CTL_HOLD;
        if (rst || freeze) begin
            ctl = CTL_HOLD;
        end else if ((state == STALL) || haz_any) begin
            ctl = CTL_STALL;
        end else begin
            ctl             = CTL_RUN;
            ctl.if_id_flush = redirect;
        end
    end

    // BL2 needs one extra stall after the detection cycle; cnt tracks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 1'b0;
        end else if (!freeze) begin
            case (state)
                RUN: begin
                    if (haz_bl2) begin
                        state <= STALL;
                        cnt   <= 1'b1;
                    end
                end
                STALL: begin
                    cnt <= 1'b0;
                    if (cnt == 1'b1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 1'b0;
                end
            endcase
        end
    end

    assign PC_write     = ctl.pc_write;
    assign IF_ID_write  = ctl.if_id_write;
    assign IF_ID_flush  = ctl.if_id_flush;
    assign ID_EX_bubble = ctl.id_ex_bubble;
    assign EX_MEM_write = ctl.ex_mem_write;
    assign MEM_WB_write = ctl.mem_wb_write;
    assign hazard_busy  = (state == STALL);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .inc   (ctl.id_ex_bubble),
        .clk   (clk),
        .rst   (rst),
        .value (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .inc   (freeze & ~rst),
        .clk   (clk),
        .rst   (rst),
        .value (freeze_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .inc   (ctl.if_id_flush),
        .clk   (clk),
        .rst   (rst),
        .value (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed pipeline scenarios plus random traffic,
// checked against a remaining-stall-cycles model; a CNT_W=4 copy checks saturation.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic       use_rs1, use_rs2, branch, jalr, redirect;
    logic       ID_EX_memread, EX_MEM_memread, ICACHE_stall, DCACHE_stall;

    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_write, hazard_busy;
    logic [31:0] stall_cycles, freeze_cycles, flush_count;
    logic        pc4, ifid4, fl4, bub4, exm4, memwb4, busy4;
    logic [3:0]  sc4, fc4, flc4;

    hazard_stall_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .branch(branch), .jalr(jalr), .redirect(redirect),
        .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_memread(EX_MEM_memread), .EX_MEM_rd(EX_MEM_rd),
        .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .hazard_busy(hazard_busy), .stall_cycles(stall_cycles),
        .freeze_cycles(freeze_cycles), .flush_count(flush_count)
    );

    hazard_stall_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .branch(branch), .jalr(jalr), .redirect(redirect),
        .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_memread(EX_MEM_memread), .EX_MEM_rd(EX_MEM_rd),
        .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .PC_write(pc4), .IF_ID_write(ifid4), .IF_ID_flush(fl4),
        .ID_EX_bubble(bub4), .EX_MEM_write(exm4), .MEM_WB_write(memwb4),
        .hazard_busy(busy4), .stall_cycles(sc4), .freeze_cycles(fc4), .flush_count(flc4)
    );

    wire [6:0] obs  = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_write, hazard_busy};
    wire [6:0] obs4 = {pc4, ifid4, fl4, bub4, exm4, memwb4, busy4};

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2, br, jr, redir, exm;
        logic [4:0] exrd;
        logic       memm;
        logic [4:0] memrd;
        logic       ic, dc;
    } stim_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     rem = 0;          // stall cycles still owed after this one
    longint m_sc = 0, m_fc = 0, m_flc = 0;

    function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic br, input logic jr,
                                 input logic redir, input logic exm, input logic [4:0] exrd,
                                 input logic memm, input logic [4:0] memrd,
                                 input logic ic, input logic dc, input logic r);
        stim_t s;
        s.rst = r; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.br = br; s.jr = jr;
        s.redir = redir; s.exm = exm; s.exrd = exrd; s.memm = memm; s.memrd = memrd;
        s.ic = ic; s.dc = dc;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic dep(input logic [4:0] x);
        return (x != 0) && ((use_rs1 && IF_ID_rs1 == x) || (use_rs2 && IF_ID_rs2 == x));
    endfunction

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_write, hazard_busy}
    function automatic logic [6:0] model_out();
        logic busy;
        busy = (rem > 0);
        if (rst) return 7'b0;
        if (ICACHE_stall || DCACHE_stall) return {6'b0, busy};
        if (busy) return 7'b0001111;
        if ((ID_EX_memread && dep(ID_EX_rd)) || ((branch || jalr) && EX_MEM_memread && dep(EX_MEM_rd)))
            return 7'b0001110;
        return {2'b11, redirect, 4'b0110};
    endfunction

    function automatic longint clip(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [95:0] exp_cnt32();
        return {32'(clip(m_sc, 32)), 32'(clip(m_fc, 32)), 32'(clip(m_flc, 32))};
    endfunction

    function automatic logic [11:0] exp_cnt4();
        return {4'(clip(m_sc, 4)), 4'(clip(m_fc, 4)), 4'(clip(m_flc, 4))};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; IF_ID_rs1 = s.rs1; IF_ID_rs2 = s.rs2; use_rs1 = s.u1; use_rs2 = s.u2;
        branch = s.br; jalr = s.jr; redirect = s.redir; ID_EX_memread = s.exm; ID_EX_rd = s.exrd;
        EX_MEM_memread = s.memm; EX_MEM_rd = s.memrd; ICACHE_stall = s.ic; DCACHE_stall = s.dc;
        if (s.rst) begin
            rem = 0; m_sc = 0; m_fc = 0; m_flc = 0;
        end
    endtask

    // Advance the model across the coming clock edge, then move just past it.
    task automatic tick();
        logic [6:0] e;
        logic       frz;
        e   = model_out();
        frz = ICACHE_stall || DCACHE_stall;
        if (!rst) begin
            if (frz) m_fc++;
            if (e[3]) m_sc++;
            if (e[4]) m_flc++;
            if (!frz) begin
                if (rem > 0) rem--;
                else if ((branch || jalr) && ID_EX_memread && dep(ID_EX_rd)) rem = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t q[$];
        logic [6:0] e;
        q = '{st(5, 5, 1, 1, 1, 0, 1, 1, 5, 1, 5, 0, 0, 1), idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL reset[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL reset[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL reset[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
    endtask

    task automatic test_load_use();
        stim_t q[$];
        logic [6:0] e;
        logic [31:0] sc0;
        sc0 = stall_cycles;
        q = '{st(5, 1, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0),
              st(5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0),
              st(3, 9, 0, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0),
              st(9, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0),
              idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL load_use[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL load_use[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL load_use[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            if (i == 1) begin
                n_chk++; if (stall_cycles - sc0 !== 32'd1) begin n_fail++; $display("FAIL load_use_count got %0d want 1", stall_cycles - sc0); end
            end
            tick();
        end
    endtask

    task automatic test_branch_load();
        stim_t q[$];
        logic [6:0] e;
        logic [31:0] sc0;
        sc0 = stall_cycles;
        q = '{st(5, 0, 1, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL branch_load[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL branch_load[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL branch_load[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
        n_chk++; if (stall_cycles - sc0 !== 32'd2) begin n_fail++; $display("FAIL branch_load_count got %0d want 2", stall_cycles - sc0); end
    endtask

    task automatic test_jalr_mem_load();
        stim_t q[$];
        logic [6:0] e;
        q = '{st(7, 0, 1, 0, 0, 1, 0, 0, 0, 1, 7, 0, 0, 0),
              st(7, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              st(0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0),
              st(6, 7, 1, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0),
              idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL jalr_mem[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL jalr_mem[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL jalr_mem[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
    endtask

    task automatic test_freeze();
        stim_t q[$];
        logic [6:0] e;
        logic [31:0] fc0;
        fc0 = freeze_cycles;
        q = '{st(5, 0, 1, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0),
              st(5, 0, 1, 1, 1, 0, 1, 0, 0, 1, 5, 0, 1, 0),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 5, 1, 1, 0),
              st(5, 0, 1, 1, 1, 0, 1, 0, 0, 1, 5, 0, 1, 0),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0),
              st(5, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL freeze[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL freeze[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL freeze[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
        n_chk++; if (freeze_cycles - fc0 !== 32'd4) begin n_fail++; $display("FAIL freeze_count got %0d want 4", freeze_cycles - fc0); end
    endtask

    task automatic test_redirect();
        stim_t q[$];
        logic [6:0] e;
        logic [31:0] fl0;
        fl0 = flush_count;
        q = '{st(1, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              st(4, 0, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0),
              idle()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL redirect[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL redirect[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL redirect[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
        n_chk++; if (flush_count - fl0 !== 32'd1) begin n_fail++; $display("FAIL redirect_count got %0d want 1", flush_count - fl0); end
    endtask

    task automatic test_reset_mid_stall();
        stim_t q[$];
        logic [6:0] e;
        q = '{st(5, 0, 1, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0),
              st(5, 0, 1, 1, 1, 0, 1, 0, 0, 1, 5, 0, 0, 1),
              st(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        for (int k = 0; k < 20; k++) q.push_back(st(8, 8, 1, 1, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0));
        q.push_back(idle());
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL mid_reset[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL mid_reset[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL mid_reset[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
        n_chk++; if (sc4 !== 4'd15) begin n_fail++; $display("FAIL sat4_stall got %0d want 15", sc4); end
        n_chk++; if (stall_cycles !== 32'd20) begin n_fail++; $display("FAIL wide_stall got %0d want 20", stall_cycles); end
    endtask

    task automatic test_random();
        stim_t s;
        logic [6:0] e;
        for (int i = 0; i < 400; i++) begin
            s = st(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), 1'b0);
            apply(s);
            @(negedge clk);
            e = model_out();
            n_chk++; if (obs !== e || obs4 !== e) begin n_fail++; $display("FAIL random[%0d] ctl got %b/%b want %b", i, obs, obs4, e); end
            n_chk++; if ({stall_cycles, freeze_cycles, flush_count} !== exp_cnt32()) begin n_fail++; $display("FAIL random[%0d] cnt got %h want %h", i, {stall_cycles, freeze_cycles, flush_count}, exp_cnt32()); end
            n_chk++; if ({sc4, fc4, flc4} !== exp_cnt4()) begin n_fail++; $display("FAIL random[%0d] cnt4 got %h want %h", i, {sc4, fc4, flc4}, exp_cnt4()); end
            tick();
        end
    endtask

    initial begin
        apply(idle());
        rst = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_branch_load();
        test_jalr_mem_load();
        test_freeze();
        test_redirect();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
